// File: rtl/acionador_motores.sv
// Wheel drive stage: turns avancar/girar commands into PWM and direction outputs for
// both H-bridges, with soft-start/soft-stop duty ramps and a dead time before reversal.
module acionador_motores #(
   parameter int PWM_BITS    = 8,
   parameter int DUTY_MAX    = 200,
   parameter int RAMP_DIV    = 4,
   parameter int DEAD_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic avancar,
   input  logic girar,
   output logic pwm_esq,
   output logic pwm_dir,
   output logic dir_esq,
   output logic dir_dir,
   output logic ocupado
);

   localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

   typedef enum logic [2:0] {
      PARADO,
      ACELERANDO,
      RODANDO,
      FREANDO,
      ZONA_MORTA
   } estado_t;

   estado_t             state_reg, state_next;
   logic [PWM_BITS-1:0] duty_reg, duty_next;
   logic [PWM_BITS-1:0] pwm_cnt_reg;
   logic [DIV_W-1:0]    div_reg;
   logic [DEAD_W-1:0]   dead_reg, dead_next;
   logic                dir_esq_reg, dir_esq_next;
   logic                dir_dir_reg, dir_dir_next;
   logic                avancar_reg, girar_reg;
   logic                pwm_reg, ocupado_reg;

   logic cmd_parar, tgt_dir, dirs_differ, tick;

   // girar wins over avancar; the left wheel target is forward in both moving commands
   assign cmd_parar   = !avancar_reg && !girar_reg;
   assign tgt_dir     = !girar_reg;
   assign dirs_differ = !cmd_parar && (!dir_esq_reg || (dir_dir_reg != tgt_dir));
   assign tick        = (div_reg == DIV_W'(RAMP_DIV - 1));

   always_comb begin
      state_next   = state_reg;
      duty_next    = duty_reg;
      dead_next    = dead_reg;
      dir_esq_next = dir_esq_reg;
      dir_dir_next = dir_dir_reg;
      case (state_reg)
         PARADO: begin
            if (dirs_differ) begin
               state_next = ZONA_MORTA;
               dead_next  = '0;
            end else if (!cmd_parar) begin
               state_next = ACELERANDO;
            end
         end
         ACELERANDO: begin
            if (cmd_parar || dirs_differ)
               state_next = FREANDO;
            else if (duty_reg == PWM_BITS'(DUTY_MAX))
               state_next = RODANDO;
            else if (tick)
               duty_next = duty_reg + 1'b1;
         end
         RODANDO: begin
            if (cmd_parar || dirs_differ)
               state_next = FREANDO;
         end
         FREANDO: begin
            if (!cmd_parar && !dirs_differ) begin
               state_next = ACELERANDO;
            end else if (duty_reg == '0) begin
               if (cmd_parar) begin
                  state_next = PARADO;
               end else begin
                  state_next = ZONA_MORTA;
                  dead_next  = '0;
               end
            end else if (tick) begin
               duty_next = duty_reg - 1'b1;
            end
         end
         ZONA_MORTA: begin
            // Directions are only ever loaded here, after a full PWM-off window
            if (dead_reg == DEAD_W'(DEAD_CYCLES - 1)) begin
               if (cmd_parar) begin
                  state_next = PARADO;
               end else begin
                  state_next   = ACELERANDO;
                  dir_esq_next = 1'b1;
                  dir_dir_next = tgt_dir;
               end
            end else begin
               dead_next = dead_reg + 1'b1;
            end
         end
         default: state_next = PARADO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= PARADO;
         duty_reg    <= '0;
         pwm_cnt_reg <= '0;
         div_reg     <= '0;
         dead_reg    <= '0;
         dir_esq_reg <= 1'b1;
         dir_dir_reg <= 1'b1;
         avancar_reg <= 1'b0;
         girar_reg   <= 1'b0;
         pwm_reg     <= 1'b0;
         ocupado_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         duty_reg    <= duty_next;
         pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
         div_reg     <= tick ? '0 : div_reg + 1'b1;
         dead_reg    <= dead_next;
         dir_esq_reg <= dir_esq_next;
         dir_dir_reg <= dir_dir_next;
         avancar_reg <= avancar;
         girar_reg   <= girar;
         pwm_reg     <= (pwm_cnt_reg < duty_reg);
         ocupado_reg <= (state_next == FREANDO) || (state_next == ZONA_MORTA);
      end
   end

   assign pwm_esq = pwm_reg;
   assign pwm_dir = pwm_reg;
   assign dir_esq = dir_esq_reg;
   assign dir_dir = dir_dir_reg;
   assign ocupado = ocupado_reg;

endmodule

// File: tb/tb_acionador_motores.sv
// Bench for acionador_motores: directed command sequences plus random segments, every
// cycle compared against a duty/countdown reference model.
module tb_acionador_motores;

   localparam int PWM_BITS    = 8;
   localparam int DUTY_MAX    = 200;
   localparam int RAMP_DIV    = 4;
   localparam int DEAD_CYCLES = 16;

   localparam int CMD_PARAR  = 0;
   localparam int CMD_FRENTE = 1;
   localparam int CMD_GIRO   = 2;
   localparam int PH_IDLE    = 0;
   localparam int PH_UP      = 1;
   localparam int PH_DOWN    = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic avancar = 1'b1;
   logic girar = 1'b0;
   logic pwm_esq, pwm_dir, dir_esq, dir_dir, ocupado;

   int checks = 0;
   int errors = 0;

   // reference model: ramp level, dead-time countdown and a coarse motion phase
   int m_duty = 0, m_dead = 0, m_phase = PH_IDLE, m_cycle = 0, m_cmd = CMD_PARAR;
   bit m_de = 1'b1, m_dd = 1'b1, m_pwm = 1'b0, m_ocup = 1'b0;

   int quiet = 0, hi_esq = 0, hi_dir = 0, ocup_cnt = 0;
   bit prev_de = 1'b1, prev_dd = 1'b1, edge_rst = 1'b0;

   always #5 clock = ~clock;

   acionador_motores #(
      .PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX), .RAMP_DIV(RAMP_DIV), .DEAD_CYCLES(DEAD_CYCLES)
   ) dut (
      .clock(clock), .reset(reset), .avancar(avancar), .girar(girar),
      .pwm_esq(pwm_esq), .pwm_dir(pwm_dir), .dir_esq(dir_esq), .dir_dir(dir_dir),
      .ocupado(ocupado)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step();
      bit tdd, differ, tick;
      int cnt;
      if (reset) begin
         m_duty = 0; m_dead = 0; m_phase = PH_IDLE; m_cycle = 0; m_cmd = CMD_PARAR;
         m_de = 1'b1; m_dd = 1'b1; m_pwm = 1'b0; m_ocup = 1'b0;
         return;
      end
      tdd    = (m_cmd != CMD_GIRO);
      differ = (m_cmd != CMD_PARAR) && (m_de != 1'b1 || m_dd != tdd);
      tick   = (m_cycle % RAMP_DIV) == (RAMP_DIV - 1);
      cnt    = m_cycle % (1 << PWM_BITS);
      m_pwm  = (cnt < m_duty);
      if (m_dead > 0) begin
         if (m_dead == 1) begin
            if (m_cmd == CMD_PARAR) m_phase = PH_IDLE;
            else begin m_de = 1'b1; m_dd = tdd; m_phase = PH_UP; end
         end
         m_dead--;
      end else if (m_phase == PH_IDLE) begin
         if (differ) m_dead = DEAD_CYCLES;
         else if (m_cmd != CMD_PARAR) m_phase = PH_UP;
      end else if (m_phase == PH_UP) begin
         if (m_cmd == CMD_PARAR || differ) m_phase = PH_DOWN;
         else if (tick && m_duty < DUTY_MAX) m_duty++;
      end else begin
         if (m_cmd != CMD_PARAR && !differ) m_phase = PH_UP;
         else if (m_duty == 0) begin
            m_phase = PH_IDLE;
            if (m_cmd != CMD_PARAR) m_dead = DEAD_CYCLES;
         end else if (tick) m_duty--;
      end
      m_ocup = (m_dead > 0) || (m_phase == PH_DOWN);
      m_cycle++;
      m_cmd = girar ? CMD_GIRO : (avancar ? CMD_FRENTE : CMD_PARAR);
   endtask

   task automatic cyc(input string tag);
      logic [4:0] obs, exp;
      @(posedge clock);
      edge_rst = reset;
      model_step();
      @(negedge clock);
      obs = {pwm_esq, pwm_dir, dir_esq, dir_dir, ocupado};
      exp = {m_pwm, m_pwm, m_de, m_dd, m_ocup};
      check_val(tag, 32'(obs), 32'(exp));
      if (!edge_rst && (dir_esq !== prev_de || dir_dir !== prev_dd))
         check_val("dead_gap", 32'(quiet >= DEAD_CYCLES), 32'd1);
      prev_de = dir_esq;
      prev_dd = dir_dir;
      if (pwm_esq || pwm_dir) quiet = 0; else quiet++;
      if (pwm_esq) hi_esq++;
      if (pwm_dir) hi_dir++;
      if (ocupado) ocup_cnt++;
   endtask

   task automatic run(input string tag, input bit av, input bit gi, input int n);
      avancar = av;
      girar   = gi;
      for (int i = 0; i < n; i++) cyc(tag);
      $display("seg %s avancar=%0b girar=%0b cycles=%0d", tag, av, gi, n);
   endtask

   initial begin
      reset = 1'b1; avancar = 1'b1; girar = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc("reset_hold");
         check_val("reset_hold_out", 32'({pwm_esq, pwm_dir, dir_esq, dir_dir, ocupado}),
                   32'(5'b00110));
      end
      $display("seg reset_hold cycles=3");
      reset = 1'b0;

      run("fwd_ramp", 1'b1, 1'b0, 1000);
      hi_esq = 0; hi_dir = 0;
      run("fwd_window", 1'b1, 1'b0, 256);
      check_val("window_esq", 32'(hi_esq), 32'(DUTY_MAX));
      check_val("window_dir", 32'(hi_dir), 32'(DUTY_MAX));

      ocup_cnt = 0;
      run("abort_brake", 1'b0, 1'b1, 100);
      run("abort_resume", 1'b1, 1'b0, 900);
      check_val("abort_busy_len", 32'(ocup_cnt), 32'd100);
      check_val("abort_dirs", 32'({dir_esq, dir_dir}), 32'(2'b11));

      run("fwd_to_rot", 1'b0, 1'b1, 1000);
      check_val("rot_dirs", 32'({dir_esq, dir_dir}), 32'(2'b10));
      check_val("rot_busy", 32'(ocupado), 32'd0);

      run("rot_to_fwd", 1'b1, 1'b0, 1000);
      check_val("fwd_dirs", 32'({dir_esq, dir_dir}), 32'(2'b11));

      run("stop", 1'b0, 1'b0, 900);
      check_val("stop_idle", 32'({pwm_esq, pwm_dir, ocupado}), 32'd0);

      ocup_cnt = 0;
      run("glitch_giro", 1'b0, 1'b1, 2);
      run("glitch_parar", 1'b0, 1'b0, 30);
      check_val("glitch_dead_len", 32'(ocup_cnt), 32'(DEAD_CYCLES));
      check_val("glitch_dirs", 32'({dir_esq, dir_dir}), 32'(2'b11));
      check_val("glitch_pwm", 32'({pwm_esq, pwm_dir}), 32'd0);

      avancar = 1'b1; girar = 1'b0;
      for (int i = 0; i < 2000 && !(m_phase == PH_UP && m_duty == 120); i++) cyc("to_120");
      check_val("reach_120", 32'(m_duty == 120), 32'd1);
      reset = 1'b1;
      cyc("reset_mid");
      check_val("reset_mid_out", 32'({pwm_esq, pwm_dir, dir_esq, dir_dir, ocupado}),
                32'(5'b00110));
      reset = 1'b0;
      $display("seg reset_mid duty_at_reset=120");

      for (int s = 0; s < 25; s++) begin
         int c, n;
         c = int'($urandom_range(0, 2));
         n = int'($urandom_range(1, 700));
         if ($urandom_range(0, 7) == 0) begin
            reset = 1'b1;
            run("rand_reset", 1'b1, 1'b0, int'($urandom_range(1, 3)));
            reset = 1'b0;
         end
         run("rand", c == CMD_FRENTE, c == CMD_GIRO, n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acionador_motores.md
Name: acionador_motores

Overview:
- Drive stage directly downstream of the wall-following controller. Consumes its `avancar`/`girar` commands and produces PWM and direction signals for the left and right wheel H-bridges of the differential-drive robot.
- Applies soft-start and soft-stop ramps to the PWM duty.
- Enforces a dead time before any wheel reverses direction, so the H-bridges never see a direction flip while PWM is active.

Parameters:
- `PWM_BITS`, 8, width of the PWM counter and of the duty value.
- `DUTY_MAX`, 200, target duty while running (1..2^PWM_BITS-1).
- `RAMP_DIV`, 4, clock cycles per ramp tick (≥1).
- `DEAD_CYCLES`, 16, cycles with PWM forced low before direction outputs change (≥1).

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `avancar`  in  1  move-forward command from controller
- `girar`  in  1  rotate command from controller
- `pwm_esq`  out  1  left wheel PWM
- `pwm_dir`  out  1  right wheel PWM
- `dir_esq`  out  1  left wheel direction, 1 = forward
- `dir_dir`  out  1  right wheel direction, 1 = forward
- `ocupado`  out  1  high while braking or in dead time

Behaviour:
- One clock domain: `clock`. Reset is synchronous and active-high; all state updates on the rising edge of `clock`.
- Reset values:
  - state = PARADO, duty = 0, PWM counter = 0, ramp divider = 0, dead counter = 0.
  - `pwm_esq` = `pwm_dir` = 0, `dir_esq` = `dir_dir` = 1, `ocupado` = 0.
- Command decode (inputs registered once; cmd latency 1 cycle):
  - `girar`=1 (any `avancar`) → GIRO, target dirs esq=1, dir=0 (turn right, away from left wall).
  - `avancar`=1, `girar`=0 → FRENTE, target dirs 1,1.
  - both 0 → PARAR, no target dirs.
- "Dirs differ" means the cmd is not PARAR and its target dirs ≠ current `dir_esq`/`dir_dir`.
- PWM generation:
  - Free-running `PWM_BITS` counter, wraps 2^PWM_BITS-1 → 0.
  - `pwm_x` <= (counter < duty), registered (1-cycle latency). Duty 0 gives constant low.
  - Both wheels share the same duty.
- Ramp tick: free-running divider 0..RAMP_DIV-1; tick asserted in the cycle it equals RAMP_DIV-1. The divider is not restarted by state changes.
- State machine:
  - **PARADO** (duty=0):
    - cmd PARAR → stay.
    - dirs equal → ACELERANDO.
    - dirs differ → ZONA_MORTA.
  - **ACELERANDO**:
    - On tick, duty+1, saturating at DUTY_MAX.
    - duty==DUTY_MAX → RODANDO.
    - cmd PARAR or dirs differ → FREANDO (checked first; no increment that cycle).
  - **RODANDO**: duty held at DUTY_MAX; cmd PARAR or dirs differ → FREANDO.
  - **FREANDO**:
    - On tick, duty-1, saturating at 0.
    - cmd non-PARAR with dirs equal → ACELERANDO immediately (ramp back up from current duty).
    - At duty==0: cmd PARAR → PARADO; dirs differ → ZONA_MORTA.
  - **ZONA_MORTA**:
    - PWM forced 0. Dead counter counts DEAD_CYCLES cycles; the counter is cleared on entry.
    - On the final cycle: if cmd is PARAR → PARADO with dirs unchanged; otherwise load dirs from the current cmd → ACELERANDO.
    - Command changes during dead time do not shorten or restart it.
- `ocupado` = 1 exactly in FREANDO and ZONA_MORTA (registered with state).
- Invariants:
  - `dir_esq`/`dir_dir` change only on the exit edge of ZONA_MORTA.
  - When they change, both `pwm` outputs have been 0 for ≥ DEAD_CYCLES consecutive cycles.
  - duty never exceeds DUTY_MAX and never underflows.
- Reset asserted mid-operation (any state, any duty): all outputs return to reset values on the next edge.
- Required response time: PWM goes low the cycle after reset; no ramp-down is performed.

Test Plan:
- **Reset hold.** Drive `reset`=1 for 3 cycles with `avancar`=1. Required: all `pwm`=0, both `dir`=1, `ocupado`=0 throughout.
- **Forward ramp.** Release reset with `avancar`=1, `girar`=0 (defaults). Required:
  - duty rises 1 per 4 cycles and reaches 200 within 800±8 cycles; state RODANDO.
  - Each 256-cycle PWM period then shows exactly 200 high cycles on both wheels.
  - dirs stay 1,1 and `ocupado` stays 0.
- **Forward to rotate.** From RODANDO, set `girar`=1. Required:
  - `ocupado`=1; duty falls to 0 in ~800 cycles.
  - PWM low for 16 more cycles, then `dir_dir`=0, `dir_esq`=1.
  - `ocupado`=0 and the ramp restarts.
  - Checker: no `dir` edge within 16 cycles of any `pwm` high.
- **Abort braking.** From RODANDO, set `girar`=1 for 100 cycles, then return to `avancar`=1. Required:
  - FREANDO → ACELERANDO from duty ≈175.
  - No dead time, dirs never change, duty returns to 200.
- **Stop with glitch.** Command PARAR, then GIRO, then PARAR again while in ZONA_MORTA. Required:
  - Dead time completes in exactly 16 cycles, then PARADO.
  - dirs unchanged (1,1), `pwm`=0.
- **Reset mid-ramp.** Assert `reset` at duty=120 in ACELERANDO. Required: next cycle `pwm`=0, duty=0, dirs=1,1, `ocupado`=0.
